// File: rtl/bcd_serial_converter.sv
// Serial double-dabble converter: 8-bit binary to three BCD digits, one shift per cycle.
// Fixed 9-cycle trigger-to-done latency; triggers arriving while busy are dropped.
module bcd_serial_converter (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       auto_en,
    input  logic [7:0] bin_in,
    output logic       busy,
    output logic       done,
    output logic [3:0] hundreds,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [19:0] work;
    logic [19:0] work_nxt;
    logic [19:0] work_adj;
    logic [2:0]  count;
    logic [2:0]  count_nxt;
    logic [7:0]  last_bin;
    logic [7:0]  last_bin_nxt;
    logic        done_nxt;
    logic [3:0]  hundreds_nxt;
    logic [3:0]  tens_nxt;
    logic [3:0]  ones_nxt;
    logic        trigger;

    assign busy    = (state != IDLE);
    assign trigger = start | (auto_en & (bin_in != last_bin));

    // Add-3 correction on the BCD columns before each shift.
    always_comb begin
        work_adj = work;
        if (work[11:8] >= 4'd5)
            work_adj[11:8] = work[11:8] + 4'd3;
        if (work[15:12] >= 4'd5)
            work_adj[15:12] = work[15:12] + 4'd3;
        if (work[19:16] >= 4'd5)
            work_adj[19:16] = work[19:16] + 4'd3;
    end

    always_comb begin
        state_nxt    = state;
        work_nxt     = work;
        count_nxt    = count;
        last_bin_nxt = last_bin;
        done_nxt     = 1'b0;
        hundreds_nxt = hundreds;
        tens_nxt     = tens;
        ones_nxt     = ones;
        case (state)
            IDLE: begin
                if (trigger) begin
                    work_nxt     = {12'd0, bin_in};
                    last_bin_nxt = bin_in;
                    count_nxt    = 3'd0;
                    state_nxt    = SHIFT;
                end
            end
            SHIFT: begin
                work_nxt  = {work_adj[18:0], 1'b0};
                count_nxt = count + 3'd1;
                if (count == 3'd7)
                    state_nxt = DONE;
            end
            DONE: begin
                hundreds_nxt = work[19:16];
                tens_nxt     = work[15:12];
                ones_nxt     = work[11:8];
                done_nxt     = 1'b1;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            work     <= 20'd0;
            count    <= 3'd0;
            last_bin <= 8'd0;
            done     <= 1'b0;
            hundreds <= 4'd0;
            tens     <= 4'd0;
            ones     <= 4'd0;
        end else begin
            state    <= state_nxt;
            work     <= work_nxt;
            count    <= count_nxt;
            last_bin <= last_bin_nxt;
            done     <= done_nxt;
            hundreds <= hundreds_nxt;
            tens     <= tens_nxt;
            ones     <= ones_nxt;
        end
    end

endmodule

// File: tb/tb_bcd_serial_converter.sv
// Scoreboard bench for bcd_serial_converter: expected digits and done cycle are queued at
// trigger time and checked by a monitor on each falling edge.
module tb_bcd_serial_converter;

    logic       clk;
    logic       reset;
    logic       start;
    logic       auto_en;
    logic [7:0] bin_in;
    logic       busy;
    logic       done;
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] ones;

    typedef struct {
        logic [3:0]  h;
        logic [3:0]  t;
        logic [3:0]  o;
        int unsigned cyc;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned cyc;
    int          n_checks;
    int          n_errors;
    logic        prev_done;

    bcd_serial_converter dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .auto_en  (auto_en),
        .bin_in   (bin_in),
        .busy     (busy),
        .done     (done),
        .hundreds (hundreds),
        .tens     (tens),
        .ones     (ones)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Called on a falling edge: the trigger is sampled at the next rising edge k,
    // so the result must appear after edge k+9.
    task automatic push_exp(input logic [7:0] v);
        exp_t e;
        e.h   = 4'(v / 100);
        e.t   = 4'((v / 10) % 10);
        e.o   = 4'(v % 10);
        e.cyc = cyc + 10;
        exp_q.push_back(e);
    endtask

    task automatic do_start(input logic [7:0] v);
        bin_in = v;
        start  = 1'b1;
        push_exp(v);
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (!reset && done) begin
            check("done_width", {31'd0, prev_done}, 0);
            if (exp_q.size() == 0) begin
                check("spurious_done", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("hundreds", {28'd0, hundreds}, {28'd0, e.h});
                check("tens",     {28'd0, tens},     {28'd0, e.t});
                check("ones",     {28'd0, ones},     {28'd0, e.o});
                check("done_cyc", cyc, e.cyc);
            end
        end
        prev_done <= done;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cyc       = 0;
        n_checks  = 0;
        n_errors  = 0;
        prev_done = 1'b0;
        reset     = 1'b1;
        start     = 1'b0;
        auto_en   = 1'b0;
        bin_in    = 8'd0;
        #1;
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_digits", {20'd0, hundreds, tens, ones}, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // 255 with busy profile across the whole conversion
        do_start(8'd255);
        check("busy_k", {31'd0, busy}, 1);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            check("busy_run", {31'd0, busy}, 1);
        end
        @(negedge clk);
        check("busy_end", {31'd0, busy}, 0);
        drain();

        // 100 then 0 triggered in the done cycle
        @(negedge clk);
        do_start(8'd100);
        repeat (9) @(negedge clk);
        check("b2b_done", {31'd0, done}, 1);
        do_start(8'd0);
        drain();

        // 47 with start and bin_in change while busy
        @(negedge clk);
        do_start(8'd47);
        repeat (2) @(negedge clk);
        bin_in = 8'd99;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        drain();
        repeat (15) @(negedge clk);
        check("ignored_q", exp_q.size(), 0);

        // 123 completes, 200 is aborted by reset
        do_start(8'd123);
        drain();
        @(negedge clk);
        do_start(8'd200);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        void'(exp_q.pop_back());
        #1;
        check("abort_busy", {31'd0, busy}, 0);
        check("abort_done", {31'd0, done}, 0);
        check("abort_digits", {20'd0, hundreds, tens, ones}, 0);
        @(negedge clk);
        bin_in = 8'd0;
        @(negedge clk);
        reset = 1'b0;
        repeat (15) @(negedge clk);
        check("abort_digits_hold", {20'd0, hundreds, tens, ones}, 0);

        // auto mode: 0 -> 63 -> 63 -> 9
        auto_en = 1'b1;
        repeat (5) @(negedge clk);
        check("auto_idle0", {31'd0, busy}, 0);
        bin_in = 8'd63;
        push_exp(8'd63);
        drain();
        repeat (12) @(negedge clk);
        check("auto_hold", {31'd0, busy}, 0);
        bin_in = 8'd9;
        push_exp(8'd9);
        drain();
        repeat (12) @(negedge clk);
        check("auto_hold2", {31'd0, busy}, 0);
        auto_en = 1'b0;

        // full sweep, back-to-back
        for (int v = 0; v < 256; v++) begin
            do_start(8'(v));
            repeat (9) @(negedge clk);
        end
        drain();
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
